// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB plus counter-based BHT branch predictor with combinational lookup
// and single-shot, stall-safe training when a resolved conditional branch leaves EX.
module branch_predict_unit #(
   parameter int unsigned BTB_ENTRIES = 64,
   parameter int unsigned BHT_ENTRIES = 256,
   parameter int unsigned CTR_BITS    = 2
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic [31:0] PCF,
   output logic [31:0] pc_predict,
   output logic        hit,
   input  logic [31:0] PCE,
   input  logic [31:0] BrNPCE,
   input  logic        branch_ex,
   input  logic        branch_hit_ex,
   input  logic        predict_ok_ex,
   input  logic        stall_e,
   output logic [31:0] branch_cnt,
   output logic [31:0] correct_cnt
);

   localparam int unsigned IW = $clog2(BTB_ENTRIES);
   localparam int unsigned HW = $clog2(BHT_ENTRIES);
   localparam int unsigned TW = 32 - IW - 2;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   logic                btbValid  [BTB_ENTRIES];
   logic [TW-1:0]       btbTag    [BTB_ENTRIES];
   logic [31:0]         btbTarget [BTB_ENTRIES];
   logic [CTR_BITS-1:0] bhtCtr    [BHT_ENTRIES];

   logic [IW-1:0] fetchBtbIdx;
   logic [TW-1:0] fetchTag;
   logic [HW-1:0] fetchBhtIdx;
   logic [IW-1:0] exBtbIdx;
   logic [TW-1:0] exTag;
   logic [HW-1:0] exBhtIdx;
   logic          upd;
   logic          unusedPcBits;

   assign fetchBtbIdx  = PCF[IW+1:2];
   assign fetchTag     = PCF[31:IW+2];
   assign fetchBhtIdx  = PCF[HW+1:2];
   assign exBtbIdx     = PCE[IW+1:2];
   assign exTag        = PCE[31:IW+2];
   assign exBhtIdx     = PCE[HW+1:2];
   assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

   // A stalled branch stays in EX, so train only on the edge where it leaves.
   assign upd = branch_ex & ~stall_e;

   // Lookup reads pre-update contents; there is no write-to-read bypass.
   always_comb begin
      hit        = 1'b0;
      pc_predict = PCF + 32'd4;
      if (btbValid[fetchBtbIdx] && (btbTag[fetchBtbIdx] == fetchTag) &&
          bhtCtr[fetchBhtIdx][CTR_BITS-1]) begin
         hit        = 1'b1;
         pc_predict = btbTarget[fetchBtbIdx];
      end
   end

   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
      end else if (upd && branch_hit_ex) begin
         btbValid[exBtbIdx] <= 1'b1;
      end
   end

   // Tag and target need no reset: they are qualified by the valid bit.
   always_ff @(posedge CPU_CLK) begin
      if (!CPU_RST && upd && branch_hit_ex) begin
         btbTag[exBtbIdx]    <= exTag;
         btbTarget[exBtbIdx] <= BrNPCE;
      end
   end

   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bhtCtr[i] <= CTR_INIT;
      end else if (upd) begin
         if (branch_hit_ex) begin
            if (bhtCtr[exBhtIdx] != CTR_MAX) bhtCtr[exBhtIdx] <= bhtCtr[exBhtIdx] + CTR_BITS'(1);
         end else begin
            if (bhtCtr[exBhtIdx] != '0) bhtCtr[exBhtIdx] <= bhtCtr[exBhtIdx] - CTR_BITS'(1);
         end
      end
   end

   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         branch_cnt  <= 32'd0;
         correct_cnt <= 32'd0;
      end else if (upd) begin
         branch_cnt  <= branch_cnt + 32'd1;
         correct_cnt <= correct_cnt + 32'(predict_ok_ex);
      end
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised BTB + BHT branch predictor for the RV32 pipeline. It replaces the fixed-size predictor instance between the IF-stage PC generator and the EX-stage branch resolution logic. Prediction is a combinational lookup on the fetch PC. Training happens on the clock edge at which a resolved conditional branch leaves EX, and is stall-safe. The block also owns the branch statistics counters, so the core top no longer needs its own flop-based double-count guard.

## Interface
Parameters:
- BTB_ENTRIES, 64, direct-mapped BTB size; power of 2, 2..1024; index width IW = log2(BTB_ENTRIES)
- BHT_ENTRIES, 256, BHT size; power of 2, 2..4096; index width HW = log2(BHT_ENTRIES)
- CTR_BITS, 2, saturating counter width, 1..4

Ports:
- CPU_CLK  in  1  clock; all state updates on the rising edge
- CPU_RST  in  1  reset, asynchronous, active-high
- PCF  in  32  fetch-stage PC
- pc_predict  out  32  predicted next PC
- hit  out  1  predict taken; registered into IF with the PC
- PCE  in  32  EX-stage PC of the resolving instruction
- BrNPCE  in  32  resolved branch target
- branch_ex  in  1  EX holds a conditional branch
- branch_hit_ex  in  1  branch actually taken
- predict_ok_ex  in  1  the EX branch was predicted correctly (direction and target)
- stall_e  in  1  EX stalled; the instruction stays in EX next cycle
- branch_cnt  out  32  resolved conditional branches
- correct_cnt  out  32  correctly predicted branches

## Operation
Lookup (combinational, IF):
- BTB index: PCF[IW+1:2]; tag: PCF[31:IW+2]
- BHT index: PCF[HW+1:2]
- Taken condition: entry valid, tags equal, and BHT counter MSB = 1
- hit = taken condition
- pc_predict = hit ? BTB target : PCF + 4 (32-bit add; wraps 0xFFFFFFFC -> 0x00000000)

Update event: upd = branch_ex & ~stall_e. An update fires exactly once per branch, on the edge at which the branch leaves EX. Indices and tag for updates come from PCE.

BHT update on upd:
- branch_hit_ex = 1: counter increments, saturating at 2^CTR_BITS-1
- branch_hit_ex = 0: counter decrements, saturating at 0

BTB update on upd:
- branch_hit_ex = 1: write valid = 1, tag from PCE, target = BrNPCE; overwrites any aliasing entry
- branch_hit_ex = 0: BTB unchanged

Statistics on upd:
- branch_cnt += 1
- correct_cnt += predict_ok_ex
- both counters wrap modulo 2^32

Reset (CPU_RST = 1):
- all BTB valid bits = 0
- all BHT counters = 2^(CTR_BITS-1) - 1 (weakly not-taken; 0 when CTR_BITS = 1)
- branch_cnt = correct_cnt = 0
- consequence: hit = 0 and pc_predict = PCF + 4
- Reset is asynchronous and overrides any update in flight.

Non-branch instructions (branch_ex = 0) never modify state, including jal and jalr.

## Timing
- Lookup latency is 0 cycles, combinational from PCF.
- An update is visible to a lookup from the cycle after its edge.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents. There is no internal bypass.
- Simultaneous aliasing: the update writes, and the lookup of the other PC reads the old entry.
- branch_ex held high with stall_e high for N cycles: zero updates during the stall, one update on the cycle stall_e = 0.
- Storage may be flops or distributed RAM. Combinational read is required, and no BRAM read latency is allowed.

## Test plan
Default parameters unless stated:
- Reset, then PCF = 0x100 -> hit = 0, pc_predict = 0x104, branch_cnt = 0.
- Taken branch resolved at PCE = 0x100 with BrNPCE = 0x80 (counter 1 -> 2) -> the next cycle, PCF = 0x100 gives hit = 1, pc_predict = 0x80. Two not-taken updates (counter -> 0) -> hit = 0, pc_predict = 0x104.
- Saturation: 5 taken updates at 0x100 -> counter = 3. One not-taken -> counter 2, hit stays 1. CTR_BITS = 1 run: one not-taken -> hit = 0.
- Aliasing: taken updates at 0x100 (target 0x80), then at 0x200 (target 0x40); both use BTB index 0 -> PCF = 0x100 misses (tag mismatch), PCF = 0x200 gives hit = 1, pc_predict = 0x40.
- Stall: branch_ex = 1 with stall_e = 1 for 3 cycles, then 0 for 1 cycle, predict_ok_ex = 1 -> branch_cnt = 1, correct_cnt = 1, one counter step.
- Reset asserted mid-run after 10 updates -> branch_cnt = correct_cnt = 0 immediately; PCF = 0x100 gives hit = 0.
